// File: rtl/iob2axi_rd_burst_pkg.sv
// Shared AXI4 read-channel field widths and constants, plus the burst FSM state
// encoding used by the native-to-AXI burst reader.
package iob2axi_rd_burst_pkg;

    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_LOCK_W  = 1;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_QOS_W   = 4;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR       = 2'd1;
    localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_MODIFIABLE = 4'd2;
    localparam logic [AXI_PROT_W-1:0]  AXI_PROT_NONSEC      = 3'd2;

    localparam int AXI_4K_BYTES = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_WAIT,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/iob2axi_rd_burst_fifo.sv
// Synchronous first-word-fall-through FIFO: the head word is always visible on
// head_data and a pop on empty is ignored.
module iob_sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    output logic [DATA_W-1:0]     head_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LVL_W'(DEPTH));
    assign level     = level_q;
    assign do_pop    = pop & ~empty;
    // A pop frees the slot in the same cycle, so push-while-full is allowed then.
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/iob2axi_rd_burst.sv
// Native-to-AXI4 read DMA master: splits a transfer into INCR bursts that never
// cross a 4 KB page and streams the returned words through a local FIFO.
module iob2axi_rd_burst
    import iob2axi_rd_burst_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int XFER_W          = 16,
    parameter int MAX_BURST       = 16,
    parameter int FIFO_DEPTH_LOG2 = 5,
    parameter int AXI_ID_W        = 1,
    parameter int AXI_ID          = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [XFER_W-1:0]      length,
    output logic                   ready,
    output logic                   error,
    input  logic                   s_valid,
    output logic [DATA_W-1:0]      s_rdata,
    output logic                   s_ready,
    output logic [AXI_ID_W-1:0]    m_axi_arid,
    output logic [ADDR_W-1:0]      m_axi_araddr,
    output logic [AXI_LEN_W-1:0]   m_axi_arlen,
    output logic [AXI_SIZE_W-1:0]  m_axi_arsize,
    output logic [AXI_BURST_W-1:0] m_axi_arburst,
    output logic [AXI_LOCK_W-1:0]  m_axi_arlock,
    output logic [AXI_CACHE_W-1:0] m_axi_arcache,
    output logic [AXI_PROT_W-1:0]  m_axi_arprot,
    output logic [AXI_QOS_W-1:0]   m_axi_arqos,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [AXI_ID_W-1:0]    m_axi_rid,
    input  logic [DATA_W-1:0]      m_axi_rdata,
    input  logic [AXI_RESP_W-1:0]  m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready
);

    // state      | meaning
    // IDLE       | ready=1, waiting for run
    // ADDR_WAIT  | size next burst, wait for FIFO room
    // ADDR       | arvalid held until arready
    // DATA       | accept beats of the single outstanding burst
    // DRAIN      | wait for consumer to empty the FIFO

    localparam int BYTES  = DATA_W / 8;
    localparam int SIZE   = $clog2(BYTES);
    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int LVL_W  = FIFO_DEPTH_LOG2 + 1;
    localparam int BEAT_W = 9;

    state_t                 state_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [ADDR_W-1:0]      araddr_q;
    logic [XFER_W-1:0]      rem_q;
    logic [AXI_LEN_W-1:0]   arlen_q;
    logic [BEAT_W-1:0]      beat_cnt_q;
    logic                   ready_q;
    logic                   error_q;
    logic                   arvalid_q;
    logic                   rready_q;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [LVL_W-1:0]       fifo_level;

    logic [12:0]            page_bytes;
    logic [31:0]            rem_w;
    logic [31:0]            page_w;
    logic [31:0]            beats_w;
    logic [31:0]            free_w;
    logic                   space_ok;
    logic                   r_beat;
    logic                   last_beat;
    logic                   beat_err;
    logic                   drain_done;

    always_comb begin
        page_bytes = 13'(AXI_4K_BYTES) - {1'b0, addr_q[11:0]};
        rem_w      = 32'(rem_q);
        page_w     = 32'(page_bytes >> SIZE);
        beats_w    = 32'(MAX_BURST);
        if (rem_w < beats_w) begin
            beats_w = rem_w;
        end
        if (page_w < beats_w) begin
            beats_w = page_w;
        end
        // Slots popped this cycle are free before the first beat can land.
        free_w   = (fifo_full ? 32'd0 : 32'(DEPTH) - 32'(fifo_level)) + 32'(fifo_pop);
        space_ok = (free_w >= beats_w);
    end

    assign r_beat     = rready_q & m_axi_rvalid;
    assign last_beat  = (beat_cnt_q == BEAT_W'(1));
    assign beat_err   = (m_axi_rresp != '0) | (m_axi_rid != AXI_ID_W'(AXI_ID)) |
                        (m_axi_rlast != last_beat);
    assign fifo_push  = r_beat;
    assign fifo_pop   = s_valid & ~fifo_empty;
    assign drain_done = fifo_empty | ((fifo_level == LVL_W'(1)) & fifo_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            araddr_q   <= '0;
            rem_q      <= '0;
            arlen_q    <= '0;
            beat_cnt_q <= '0;
            ready_q    <= 1'b1;
            error_q    <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        error_q <= 1'b0;
                        if (length != '0) begin
                            addr_q  <= addr & ~ADDR_W'(BYTES - 1);
                            rem_q   <= length;
                            ready_q <= 1'b0;
                            state_q <= ST_ADDR_WAIT;
                        end
                    end
                end
                ST_ADDR_WAIT: begin
                    if (space_ok) begin
                        araddr_q   <= addr_q;
                        arlen_q    <= AXI_LEN_W'(beats_w - 32'd1);
                        beat_cnt_q <= BEAT_W'(beats_w);
                        addr_q     <= addr_q + ADDR_W'(beats_w << SIZE);
                        rem_q      <= rem_q - XFER_W'(beats_w);
                        arvalid_q  <= 1'b1;
                        state_q    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_beat) begin
                        if (beat_err) begin
                            error_q <= 1'b1;
                        end
                        beat_cnt_q <= beat_cnt_q - BEAT_W'(1);
                        if (last_beat) begin
                            rready_q <= 1'b0;
                            state_q  <= (rem_q != '0) ? ST_ADDR_WAIT : ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    iob_sync_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (m_axi_rdata),
        .pop       (fifo_pop),
        .head_data (s_rdata),
        .level     (fifo_level),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign ready         = ready_q;
    assign error         = error_q;
    assign s_ready       = fifo_pop;
    assign m_axi_arid    = AXI_ID_W'(AXI_ID);
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = AXI_SIZE_W'(SIZE);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = '0;
    assign m_axi_arcache = AXI_CACHE_MODIFIABLE;
    assign m_axi_arprot  = AXI_PROT_NONSEC;
    assign m_axi_arqos   = '0;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
